// File: rtl/alu_result_tx.sv
// alu_result_tx: serializes ALU result words LSB-byte-first onto a byte valid/ready stream.
// Holds one word in flight plus one pending word; a further arrival is dropped and flagged.
module alu_result_tx #(
  parameter int OUT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [OUT_WIDTH-1:0] RES_DATA,
  input  logic                 RES_VALID,
  input  logic                 TX_READY,
  input  logic                 CLR_OVF,
  output logic [7:0]           TX_DATA,
  output logic                 TX_VALID,
  output logic                 BUSY,
  output logic                 OVERFLOW
);
  localparam int NUM_BYTES = OUT_WIDTH / 8;
  localparam int IW = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t               r_state;
  logic [OUT_WIDTH-1:0] r_sh;
  logic [OUT_WIDTH-1:0] r_pd;
  logic                 r_pd_v;
  logic [IW-1:0]        r_idx;
  logic                 r_ovf;
  logic                 w_last;
  logic                 w_xfer;

  assign w_last   = r_idx == IW'(NUM_BYTES - 1);
  assign w_xfer   = r_state == SEND && TX_READY;
  assign TX_VALID = r_state == SEND;
  // The word in flight is shifted down per byte, so the current byte is always the low byte.
  assign TX_DATA  = r_state == SEND ? r_sh[7:0] : 8'd0;
  assign BUSY     = r_state == SEND || r_pd_v;
  assign OVERFLOW = r_ovf;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_pd    <= '0;
      r_pd_v  <= 1'b0;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (CLR_OVF) r_ovf <= 1'b0;
      if (r_state == IDLE) begin
        if (RES_VALID) begin
          r_sh    <= RES_DATA;
          r_idx   <= '0;
          r_state <= SEND;
        end
      end else if (w_xfer && w_last) begin
        r_idx <= '0;
        if (r_pd_v) begin
          r_sh   <= r_pd;
          r_pd_v <= RES_VALID;
          if (RES_VALID) r_pd <= RES_DATA;
        end else if (RES_VALID) begin
          r_sh <= RES_DATA;
        end else begin
          r_state <= IDLE;
        end
      end else begin
        if (w_xfer) begin
          r_idx <= r_idx + 1'b1;
          r_sh  <= r_sh >> 8;
        end
        if (RES_VALID && !r_pd_v) begin
          r_pd   <= RES_DATA;
          r_pd_v <= 1'b1;
        end else if (RES_VALID) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_result_tx.sv
// tb_alu_result_tx: scoreboard bench for a 16-bit and a 32-bit alu_result_tx instance.
// A two-word-capacity queue model predicts bytes, TX_VALID, BUSY and OVERFLOW.
module tb_alu_result_tx;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] rd   [2];
  logic        rv   [2];
  logic        rdy  [2];
  logic        clr  [2];
  logic [7:0]  txd  [2];
  logic        txv  [2];
  logic        busy [2];
  logic        ovf  [2];

  int          nb   [2] = '{2, 4};
  int          cnt  [2];
  int          sent [2];
  logic        movf [2];
  logic [7:0]  eb   [2][16];
  int          hd   [2];
  int          tl   [2];
  int          errors = 0;
  int          checks = 0;

  always #5 CLK = ~CLK;

  alu_result_tx #(.OUT_WIDTH(16)) dut16 (
    .CLK(CLK), .RST(RST), .RES_DATA(rd[0][15:0]), .RES_VALID(rv[0]), .TX_READY(rdy[0]),
    .CLR_OVF(clr[0]), .TX_DATA(txd[0]), .TX_VALID(txv[0]), .BUSY(busy[0]), .OVERFLOW(ovf[0])
  );

  alu_result_tx #(.OUT_WIDTH(32)) dut32 (
    .CLK(CLK), .RST(RST), .RES_DATA(rd[1]), .RES_VALID(rv[1]), .TX_READY(rdy[1]),
    .CLR_OVF(clr[1]), .TX_DATA(txd[1]), .TX_VALID(txv[1]), .BUSY(busy[1]), .OVERFLOW(ovf[1])
  );

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, d, $time, act, exp);
    end
  endtask

  // Reference model: a FIFO of at most two words; a departing last byte frees space before arrival.
  always @(posedge CLK or negedge RST) begin
    for (int d = 0; d < 2; d++) begin
      if (!RST) begin
        cnt[d] = 0; sent[d] = 0; movf[d] = 1'b0; hd[d] = 0; tl[d] = 0;
      end else begin
        if (cnt[d] > 0 && rdy[d]) begin
          sent[d]++;
          if (sent[d] == nb[d]) begin
            sent[d] = 0;
            cnt[d]--;
          end
        end
        if (clr[d]) movf[d] = 1'b0;
        if (rv[d]) begin
          if (cnt[d] < 2) begin
            cnt[d]++;
            for (int k = 0; k < nb[d]; k++) begin
              eb[d][tl[d] % 16] = 8'((rd[d] >> (8 * k)) & 32'hFF);
              tl[d]++;
            end
          end else begin
            movf[d] = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on each accepted byte.
  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      chk("tx_valid", d, 32'(txv[d]), 32'(cnt[d] > 0));
      chk("busy", d, 32'(busy[d]), 32'(cnt[d] > 0));
      chk("overflow", d, 32'(ovf[d]), 32'(movf[d]));
      if (!txv[d]) chk("idle_data", d, 32'(txd[d]), 32'h0);
      if (txv[d] && rdy[d]) begin
        if (hd[d] == tl[d]) chk("unexpected_byte", d, 32'(txd[d]), 32'hFFFF_FFFF);
        else begin
          chk("tx_data", d, 32'(txd[d]), 32'(eb[d][hd[d] % 16]));
          hd[d]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rd[d] = '0; rv[d] = 1'b0; rdy[d] = 1'b0; clr[d] = 1'b0;
    end
    repeat (2) step();
    RST = 1'b1;
    step();
    rd[0] = 32'hA55A; rv[0] = 1'b1; rdy[0] = 1'b1;
    step();
    rv[0] = 1'b0;
    repeat (4) step();
    rdy[0] = 1'b0; rd[0] = 32'h1234; rv[0] = 1'b1;
    step();
    rv[0] = 1'b0;
    repeat (5) step();
    chk("hold_data", 0, 32'(txd[0]), 32'h34);
    rdy[0] = 1'b1;
    repeat (4) step();
    rdy[0] = 1'b0; rv[0] = 1'b1;
    rd[0] = 32'h0001; step();
    rd[0] = 32'h0002; step();
    rd[0] = 32'h0003; step();
    rv[0] = 1'b0;
    repeat (3) step();
    chk("ovf_set", 0, 32'(ovf[0]), 32'h1);
    rdy[0] = 1'b1;
    repeat (6) step();
    chk("ovf_sticky", 0, 32'(ovf[0]), 32'h1);
    clr[0] = 1'b1; step();
    clr[0] = 1'b0; step();
    chk("ovf_clear", 0, 32'(ovf[0]), 32'h0);
    rd[0] = 32'hCAFE; rv[0] = 1'b1; step();
    rv[0] = 1'b0; step();
    rd[0] = 32'hBEEF; rv[0] = 1'b1; step();
    rv[0] = 1'b0;
    repeat (4) step();
    rd[0] = 32'h7788; rv[0] = 1'b1; step();
    rv[0] = 1'b0; step();
    RST = 1'b0;
    #1;
    chk("rst_valid", 0, 32'(txv[0]), 32'h0);
    chk("rst_data", 0, 32'(txd[0]), 32'h0);
    chk("rst_busy", 0, 32'(busy[0]), 32'h0);
    step();
    RST = 1'b1;
    step();
    rd[0] = 32'h0102; rv[0] = 1'b1; step();
    rv[0] = 1'b0;
    repeat (4) step();
    rd[1] = 32'h11223344; rv[1] = 1'b1; rdy[1] = 1'b1; step();
    rv[1] = 1'b0;
    repeat (12) begin
      rdy[1] = ~rdy[1];
      step();
    end
    repeat (3000) begin
      for (int d = 0; d < 2; d++) begin
        rv[d]  = ($urandom % 3) == 0;
        rd[d]  = $urandom;
        rdy[d] = ($urandom % 4) != 0;
        clr[d] = ($urandom % 16) == 0;
      end
      step();
    end
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; rdy[d] = 1'b1; clr[d] = 1'b0;
    end
    repeat (20) step();
    for (int d = 0; d < 2; d++) chk("drained", d, 32'(tl[d] - hd[d]), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
